run_sequencer: RTL and testbench

- Hardware initiator for the processor's Start/Ack program-launch handshake.
- Launches P1, P2 and P3 in order by pulsing Start, waits for Ack from TopLevel, then scans that program's result region in data memory against a golden image.
- Reports mismatch count, first failing address, per-program cycle count and a pass/fail verdict.
- Sits beside TopLevel in on-board self-test builds, replacing the bench-driven launch sequence.

---
 rtl/run_seq_pkg.sv | 10 +
 rtl/run_sequencer_region_checker.sv | 59 +++++
 rtl/run_sequencer.sv | 127 ++++++++++++
 tb/tb_run_sequencer.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/run_seq_pkg.sv
// Shared types and program region table for the Start/Ack launch sequencer.
package run_seq_pkg;
  localparam int NUM_PROGS = 3;

  typedef enum logic [2:0] {IDLE, LAUNCH, ACK_LOW, ACK_HIGH, CHECK, DONE} state_e;

  // Inclusive result-region bounds, indexed by program number (P1 at [0]).
  localparam logic [NUM_PROGS-1:0][7:0] REGION_LO = {8'd192, 8'd94, 8'd30};
  localparam logic [NUM_PROGS-1:0][7:0] REGION_HI = {8'd194, 8'd123, 8'd59};
endpackage

// File: rtl/run_sequencer_region_checker.sv
// Walks one result region an address per cycle and compares DUT memory against
// golden memory one cycle later; errors accumulate across the whole run.
module region_checker #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              clear_i,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] lo_i,
  input  logic [ADDR_W-1:0] hi_i,
  input  logic [DATA_W-1:0] mem_data_i,
  input  logic [DATA_W-1:0] gold_data_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic              finish_o,
  output logic [7:0]        err_cnt_o,
  output logic [ADDR_W-1:0] first_addr_o
);
  // [0]: an address is issued this cycle, [1]: its read data is present this cycle
  logic [1:0]        vld_pipe_q;
  logic [ADDR_W-1:0] addr_q, cmp_addr_q, first_q;
  logic [7:0]        err_q;
  logic              mismatch;

  assign mismatch = vld_pipe_q[1] && (mem_data_i != gold_data_i);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      vld_pipe_q <= '0;
      addr_q     <= '0;
      cmp_addr_q <= '0;
      first_q    <= '0;
      err_q      <= '0;
    end else begin
      vld_pipe_q[1] <= vld_pipe_q[0];
      cmp_addr_q    <= addr_q;
      if (start_i) begin
        addr_q        <= lo_i;
        vld_pipe_q[0] <= 1'b1;
      end else if (vld_pipe_q[0]) begin
        if (addr_q == hi_i) vld_pipe_q[0] <= 1'b0;
        else                addr_q        <= addr_q + ADDR_W'(1);
      end
      if (clear_i) begin
        err_q   <= '0;
        first_q <= '0;
      end else if (mismatch) begin
        if (err_q != 8'hFF) err_q   <= err_q + 8'd1;
        if (err_q == 8'h00) first_q <= cmp_addr_q;
      end
    end
  end

  assign addr_o       = addr_q;
  assign finish_o     = vld_pipe_q[1] & ~vld_pipe_q[0];
  assign err_cnt_o    = err_q;
  assign first_addr_o = first_q;
endmodule

// File: rtl/run_sequencer.sv
// Self-test initiator: launches P1..P3 via Start/Ack, then checks each program's
// result region against golden memory and reports a verdict.
module run_sequencer
  import run_seq_pkg::*;
#(
  parameter int ADDR_W       = 8,
  parameter int DATA_W       = 8,
  parameter int TIMEOUT_W    = 16,
  parameter int START_CYCLES = 1
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 Go,
  output logic                 Start,
  input  logic                 Ack,
  output logic [ADDR_W-1:0]    MemAddr,
  input  logic [DATA_W-1:0]    MemData,
  input  logic [DATA_W-1:0]    GoldData,
  output logic [1:0]           ProgIdx,
  output logic                 Busy,
  output logic                 Done,
  output logic                 Pass,
  output logic                 TimedOut,
  output logic [7:0]           ErrCount,
  output logic [ADDR_W-1:0]    FirstErrAddr,
  output logic [TIMEOUT_W-1:0] LastCycles
);
  localparam logic [TIMEOUT_W-1:0] T_MAX  = '1;
  localparam logic [TIMEOUT_W-1:0] S_LAST = TIMEOUT_W'(START_CYCLES - 1);

  state_e               state_q, state_d;
  logic [TIMEOUT_W-1:0] cnt_q, cnt_d, last_q, last_d;
  logic [1:0]           prog_q, prog_d;
  logic                 tmo_q, tmo_d;
  logic                 chk_start, chk_clear, chk_finish;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      last_q  <= '0;
      prog_q  <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      prog_q  <= prog_d;
      tmo_q   <= tmo_d;
    end
  end

  // cnt_q counts Start cycles in LAUNCH, then Ack-wait cycles from 0 at Start fall.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    last_d    = last_q;
    prog_d    = prog_q;
    tmo_d     = tmo_q;
    chk_start = 1'b0;
    chk_clear = 1'b0;
    case (state_q)
      IDLE, DONE: if (Go) begin
        chk_clear = 1'b1;
        tmo_d     = 1'b0;
        prog_d    = '0;
        cnt_d     = '0;
        state_d   = LAUNCH;
      end
      LAUNCH: if (cnt_q == S_LAST) begin
        cnt_d   = '0;
        state_d = ACK_LOW;
      end else begin
        cnt_d = cnt_q + TIMEOUT_W'(1);
      end
      ACK_LOW, ACK_HIGH: begin
        if (state_q == ACK_HIGH && Ack) begin
          last_d    = cnt_q;
          chk_start = 1'b1;
          state_d   = CHECK;
        end else if (cnt_q == T_MAX) begin
          tmo_d   = 1'b1;
          last_d  = T_MAX;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + TIMEOUT_W'(1);
          // a stale Ack from the previous program must drop before a new one counts
          if (state_q == ACK_LOW && !Ack) state_d = ACK_HIGH;
        end
      end
      CHECK: if (chk_finish) begin
        if (prog_q == 2'(NUM_PROGS - 1)) begin
          state_d = DONE;
        end else begin
          prog_d  = prog_q + 2'd1;
          cnt_d   = '0;
          state_d = LAUNCH;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  region_checker #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_chk (
    .Clk          (Clk),
    .Reset        (Reset),
    .clear_i      (chk_clear),
    .start_i      (chk_start),
    .lo_i         (ADDR_W'(REGION_LO[prog_q])),
    .hi_i         (ADDR_W'(REGION_HI[prog_q])),
    .mem_data_i   (MemData),
    .gold_data_i  (GoldData),
    .addr_o       (MemAddr),
    .finish_o     (chk_finish),
    .err_cnt_o    (ErrCount),
    .first_addr_o (FirstErrAddr)
  );

  assign Start      = (state_q == LAUNCH);
  assign Busy       = (state_q == LAUNCH) || (state_q == ACK_LOW) ||
                      (state_q == ACK_HIGH) || (state_q == CHECK);
  assign Done       = (state_q == DONE);
  assign Pass       = Done && (ErrCount == 8'd0) && !tmo_q;
  assign TimedOut   = tmo_q;
  assign ProgIdx    = prog_q;
  assign LastCycles = last_q;
endmodule

// File: tb/tb_run_sequencer.sv
// Randomized bench: a TopLevel Ack model plus memory images; expected results are
// recomputed from the region table and Ack timing, not from the DUT's internals.
module tb_run_sequencer;
  localparam int AW = 8, DW = 8, TW = 6;

  logic          Clk = 1'b0;
  logic          Reset, Go, Start, Busy, Done, Pass, TimedOut;
  logic          Ack = 1'b0;
  logic [AW-1:0] MemAddr, FirstErrAddr;
  logic [DW-1:0] MemData, GoldData;
  logic [1:0]    ProgIdx;
  logic [7:0]    ErrCount;
  logic [TW-1:0] LastCycles;

  run_sequencer #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_W(TW), .START_CYCLES(1)) dut (
    .Clk(Clk), .Reset(Reset), .Go(Go), .Start(Start), .Ack(Ack),
    .MemAddr(MemAddr), .MemData(MemData), .GoldData(GoldData),
    .ProgIdx(ProgIdx), .Busy(Busy), .Done(Done), .Pass(Pass),
    .TimedOut(TimedOut), .ErrCount(ErrCount), .FirstErrAddr(FirstErrAddr),
    .LastCycles(LastCycles)
  );

  always #5 Clk = ~Clk;

  logic [DW-1:0] mem  [256];
  logic [DW-1:0] gold [256];
  int LO [3] = '{30, 94, 192};
  int HI [3] = '{59, 123, 194};

  always @(posedge Clk) begin
    MemData  <= mem[MemAddr];
    GoldData <= gold[MemAddr];
  end

  // TopLevel model: t counts cycles since Start fell; Ack keeps its stale level
  // until drop_dly, is low until rise_dly, then high (never for never_prog).
  int t = 1000, start_total = 0;
  int drop_dly, rise_dly, never_prog;
  bit ack_idle_val;

  always @(negedge Clk) begin
    if (Start === 1'b1) begin
      t = -1;
      start_total++;
    end else if (t < 1000) t++;
    if (Busy !== 1'b1) Ack = ack_idle_val;
    else if (t >= 0) begin
      if (int'(ProgIdx) == never_prog) begin
        if (t >= drop_dly) Ack = 1'b0;
      end else if (t >= rise_dly) Ack = 1'b1;
      else if (t >= drop_dly)     Ack = 1'b0;
    end
  end

  int n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ".start"}, int'(Start), 0);
    chk({tag, ".busy"},  int'(Busy), 0);
    chk({tag, ".done"},  int'(Done), 0);
    chk({tag, ".pass"},  int'(Pass), 0);
    chk({tag, ".tmo"},   int'(TimedOut), 0);
    chk({tag, ".err"},   int'(ErrCount), 0);
    chk({tag, ".first"}, int'(FirstErrAddr), 0);
    chk({tag, ".last"},  int'(LastCycles), 0);
    chk({tag, ".prog"},  int'(ProgIdx), 0);
    chk({tag, ".addr"},  int'(MemAddr), 0);
  endtask

  task automatic sync_gold();
    for (int a = 0; a < 256; a++) gold[a] = mem[a];
  endtask

  // Pulse Go, optionally pulse it again while busy, wait for Done, then compare.
  task automatic run_and_check(input string tag, input int extra_go);
    int  s0, errs, first, nscan, exp_prog;
    bit  ok, tmo;
    tmo      = (never_prog >= 0);
    nscan    = tmo ? never_prog : 3;
    exp_prog = tmo ? never_prog : 2;
    errs = 0; first = 0;
    for (int p = 0; p < nscan; p++)
      for (int a = LO[p]; a <= HI[p]; a++)
        if (mem[a] !== gold[a]) begin
          if (errs == 0) first = a;
          if (errs < 255) errs++;
        end
    s0 = start_total;
    @(negedge Clk) Go = 1'b1;
    @(negedge Clk) Go = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if (Done === 1'b1) begin ok = 1'b1; break; end
      Go = (i == extra_go);
      @(negedge Clk);
    end
    Go = 1'b0;
    chk({tag, ".done"},   int'(ok), 1);
    chk({tag, ".busy"},   int'(Busy), 0);
    chk({tag, ".tmo"},    int'(TimedOut), int'(tmo));
    chk({tag, ".pass"},   int'(Pass), int'(!tmo && errs == 0));
    chk({tag, ".err"},    int'(ErrCount), errs);
    chk({tag, ".first"},  int'(FirstErrAddr), first);
    chk({tag, ".last"},   int'(LastCycles), tmo ? (2**TW - 1) : rise_dly);
    chk({tag, ".prog"},   int'(ProgIdx), exp_prog);
    chk({tag, ".starts"}, start_total - s0, exp_prog + 1);
  endtask

  initial begin
    bit ok;
    Reset = 1'b1; Go = 1'b0;
    drop_dly = 0; rise_dly = 20; never_prog = -1; ack_idle_val = 1'b0;
    for (int a = 0; a < 256; a++) mem[a] = DW'($urandom);
    sync_gold();
    repeat (3) @(negedge Clk);
    check_zero("reset");
    Reset = 1'b0;

    run_and_check("clean", -1);

    mem[95] = 8'h3C; gold[95] = 8'h3D;
    run_and_check("one_err", -1);
    sync_gold();

    ack_idle_val = 1'b1; drop_dly = 3; rise_dly = 13;
    run_and_check("stale_ack", -1);
    ack_idle_val = 1'b0; drop_dly = 0; rise_dly = 20;

    never_prog = 1;
    run_and_check("timeout", -1);
    repeat (5) @(negedge Clk);
    chk("timeout.hold_done", int'(Done), 1);
    never_prog = -1;

    for (int p = 0; p < 3; p++)
      for (int a = LO[p]; a <= HI[p]; a++) gold[a] = ~mem[a];
    run_and_check("all_err", -1);
    sync_gold();

    for (int it = 0; it < 5; it++) begin
      for (int a = 0; a < 256; a++) mem[a] = DW'($urandom);
      sync_gold();
      for (int k = $urandom_range(0, 4); k > 0; k--) begin
        int a;
        a = $urandom_range(0, 255);
        gold[a] = mem[a] ^ DW'($urandom_range(1, 255));
      end
      ack_idle_val = 1'($urandom_range(0, 1));
      drop_dly     = $urandom_range(0, 5);
      rise_dly     = drop_dly + 1 + $urandom_range(0, 30);
      run_and_check($sformatf("rand%0d", it), $urandom_range(3, 40));
    end
    ack_idle_val = 1'b0; drop_dly = 0; rise_dly = 20;

    sync_gold();
    gold[40] = mem[40] ^ 8'h01;
    @(negedge Clk) Go = 1'b1;
    @(negedge Clk) Go = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (Busy === 1'b1 && ProgIdx == 2'd1 && int'(MemAddr) >= 96) begin ok = 1'b1; break; end
      @(negedge Clk);
    end
    chk("midrst.reach_p2", int'(ok), 1);
    chk("midrst.err_before", int'(ErrCount), 1);
    Reset = 1'b1;
    @(negedge Clk);
    check_zero("midrst");
    Reset = 1'b0;
    sync_gold();
    run_and_check("rerun", -1);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
